seg_display_reader: RTL and testbench

- Receiver side of the team's multiplexed 7-segment display interface: watches the segment lines (a..g) and the digit anode strobes that the BCD-to-7-segment decoders drive.
- Reconstructs the BCD value shown on each of 4 digits, flagging illegal patterns and stale digits.
- Used as a loopback checker and board-level readback next to the display driver path.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_to_bcd.sv | 32 +++
 rtl/seg_display_reader.sv | 185 ++++++++++++++++++
 tb/tb_seg_display_reader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants for the display encode and readback paths.
// Segment patterns are active-high with bit 0 = a ... bit 6 = g.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Position of the set bit; only meaningful when the input is one-hot.
  function automatic logic [1:0] onehot_idx(input logic [NUM_DIGITS-1:0] a);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-high segment pattern back to BCD.
// Anything that is neither a decimal glyph nor blank is reported as illegal.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] s,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       legal
);

  always_comb begin
    bcd   = BCD_BLANK;
    blank = 1'b0;
    legal = 1'b1;
    case (s)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_display_reader.sv
// Readback of a multiplexed 7-segment display: debounces each anode/segment
// combination, reconstructs per-digit BCD and ages out digits no longer refreshed.
module seg_display_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT        = 1000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  valid,
  output logic [3:0]  err,
  output logic        update,
  output logic [1:0]  upd_idx
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  logic [6:0]    s_q, s_d;
  logic [3:0]    a_q, a_d;
  state_t        state_q, state_d;
  logic [6:0]    ref_s_q, ref_s_d;
  logic [3:0]    ref_a_q, ref_a_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          update_q, update_d;
  logic [1:0]    upd_idx_q, upd_idx_d;

  logic          sel_ok, changed, capture, refresh;
  logic [1:0]    cur_idx;
  logic [3:0]    dec_bcd;
  logic          dec_blank, dec_legal;

  // Normalise to active-high before registering so everything downstream is polarity-free.
  always_comb begin
    s_d = SEG_ACTIVE_LOW ? ~seg : seg;
    a_d = SEG_ACTIVE_LOW ? ~an  : an;
  end

  assign sel_ok  = $onehot(a_q);
  assign changed = (a_q != ref_a_q) || (s_q != ref_s_q);
  assign cur_idx = onehot_idx(ref_a_q);

  always_comb begin
    state_d   = state_q;
    ref_s_d   = ref_s_q;
    ref_a_d   = ref_a_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    refresh   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_ok) begin
          ref_a_d = a_q;
          ref_s_d = s_q;
          cnt_d   = CW'(1);
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (!sel_ok) begin
          state_d = IDLE;
        end else if (changed) begin
          ref_a_d = a_q;
          ref_s_d = s_q;
          cnt_d   = CW'(1);
        end else if (int'(cnt_q) + 1 >= STABLE_CYCLES) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (!sel_ok) begin
          state_d = IDLE;
        end else if (changed) begin
          ref_a_d = a_q;
          ref_s_d = s_q;
          cnt_d   = CW'(1);
          state_d = COUNT;
        end else begin
          refresh = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    update_d  = capture;
    upd_idx_d = capture ? cur_idx : upd_idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= '0;
      a_q       <= '0;
      state_q   <= IDLE;
      ref_s_q   <= '0;
      ref_a_q   <= '0;
      cnt_q     <= '0;
      update_q  <= 1'b0;
      upd_idx_q <= 2'd0;
    end else begin
      s_q       <= s_d;
      a_q       <= a_d;
      state_q   <= state_d;
      ref_s_q   <= ref_s_d;
      ref_a_q   <= ref_a_d;
      cnt_q     <= cnt_d;
      update_q  <= update_d;
      upd_idx_q <= upd_idx_d;
    end
  end

  seg7_to_bcd u_dec (
    .s     (ref_s_q),
    .bcd   (dec_bcd),
    .blank (dec_blank),
    .legal (dec_legal)
  );

  // Per-digit value, error flag and refresh timer.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0]    dig_q, dig_d;
    logic          val_q, val_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          load;

    always_comb begin
      load  = (capture || refresh) && (cur_idx == 2'(gi));
      dig_d = dig_q;
      val_d = val_q;
      err_d = err_q;
      tmo_d = tmo_q;
      if (load) begin
        // A reload beats a same-cycle expiry, so valid never glitches low.
        tmo_d = TMO_LOAD;
        val_d = 1'b1;
        if (capture) begin
          if (dec_legal) begin
            dig_d = dec_blank ? BCD_BLANK : dec_bcd;
            err_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end else if (tmo_q != '0) begin
        tmo_d = tmo_q - TW'(1);
        if (tmo_q == TW'(1)) val_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dig_q <= BCD_BLANK;
        val_q <= 1'b0;
        err_q <= 1'b0;
        tmo_q <= '0;
      end else begin
        dig_q <= dig_d;
        val_q <= val_d;
        err_q <= err_d;
        tmo_q <= tmo_d;
      end
    end

    assign digits[4*gi +: 4] = dig_q;
    assign valid[gi]         = val_q;
    assign err[gi]           = err_q;
  end

  assign update  = update_q;
  assign upd_idx = upd_idx_q;

endmodule

// File: tb/tb_seg_display_reader.sv
// Self-checking bench for seg_display_reader: run-length reference model plus
// directed scenarios and randomized anode/segment traffic.
module tb_seg_display_reader;

  localparam int STABLE  = 4;
  localparam int TMO     = 64;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an  = 4'hF;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        update;
  logic [1:0]  upd_idx;

  int n_tests  = 0;
  int n_fail   = 0;
  int upd_seen = 0;

  seg_display_reader #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT        (TMO),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .seg     (seg),
    .an      (an),
    .digits  (digits),
    .valid   (valid),
    .err     (err),
    .update  (update),
    .upd_idx (upd_idx)
  );

  always #5 clk = ~clk;

  // Reference model: the pin sample seen at one edge acts at the next edge.
  // A digit is captured when a one-hot sample has repeated exactly STABLE
  // times, and refreshed while the same sample keeps repeating.
  logic [3:0] m_dig [4];
  bit         m_val [4];
  bit         m_err [4];
  int         m_tmo [4];
  bit         m_upd;
  int         m_uidx;
  int         run;
  logic [10:0] prev;

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == SEG_TAB[i]) return i;
    if (s == 7'h00) return 15;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_dig[k] = 4'hF; m_val[k] = 0; m_err[k] = 0; m_tmo[k] = 0;
    end
    m_upd = 0; m_uidx = 0; run = 0; prev = '0;
  endtask

  task automatic model_step();
    logic [10:0] cur;
    int pidx, v;
    pidx = 0;
    for (int k = 0; k < 4; k++) if (prev[7+k]) pidx = k;
    m_upd = 0;
    for (int k = 0; k < 4; k++) begin
      if (run >= STABLE && pidx == k) begin
        if (run == STABLE) begin
          v = decode(prev[6:0]);
          if (v < 0) m_err[k] = 1;
          else begin m_dig[k] = 4'(v); m_err[k] = 0; end
          m_upd = 1; m_uidx = k;
        end
        m_tmo[k] = TMO; m_val[k] = 1;
      end else if (m_tmo[k] > 0) begin
        m_tmo[k]--;
        if (m_tmo[k] == 0) m_val[k] = 0;
      end
    end
    cur = {~an, ~seg};
    if ($onehot(cur[10:7])) begin
      if (run > 0 && cur == prev) run = (run > STABLE) ? run : run + 1;
      else run = 1;
    end else begin
      run = 0;
    end
    prev = cur;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    logic [15:0] e_dig;
    logic [3:0]  e_val, e_err;
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_dig = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        e_val = {m_val[3], m_val[2], m_val[1], m_val[0]};
        e_err = {m_err[3], m_err[2], m_err[1], m_err[0]};
        n_tests++;
        if (digits !== e_dig || valid !== e_val || err !== e_err ||
            update !== m_upd || upd_idx !== 2'(m_uidx)) begin
          n_fail++;
          $display("FAIL model_cmp t=%0t digits %h/%h valid %b/%b err %b/%b update %b/%b upd_idx %0d/%0d (got/required)",
                   $time, digits, e_dig, valid, e_val, err, e_err, update, m_upd, upd_idx, m_uidx);
        end
        if (update === 1'b1) upd_seen++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Drive active-high values onto the active-low pins at a falling edge.
  task automatic drive(input logic [3:0] a_hi, input logic [6:0] s_hi);
    @(negedge clk);
    an  = ~a_hi;
    seg = ~s_hi;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, lat;
    logic [3:0] ra;
    logic [6:0] rs;
    int kind, hl;

    // Reset and idle pins
    rst = 1'b1; seg = 7'h7F; an = 4'hF;
    hold(3);
    rst = 1'b0;
    u0 = upd_seen;
    hold(10);
    check("idle_no_update", 32'(upd_seen - u0), 32'd0);
    check("idle_valid", 32'(valid), 32'h0);
    check("idle_digits", 32'(digits), 32'hFFFF);

    // Single digit: 3 on digit 0, update 5 edges after the pins change
    u0 = upd_seen;
    drive(4'b0001, 7'h4F);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (update === 1'b1) begin lat = k; break; end
    end
    check("single_latency", 32'(lat), 32'd5);
    check("single_upd_idx", 32'(upd_idx), 32'd0);
    hold(6);
    check("single_update_count", 32'(upd_seen - u0), 32'd1);
    check("single_digit", 32'(digits[3:0]), 32'd3);
    check("single_valid", 32'(valid), 32'b0001);
    check("single_err", 32'(err), 32'h0);

    // Asynchronous reset between edges
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_digits", 32'(digits), 32'hFFFF);
    check("async_rst_valid", 32'(valid), 32'h0);
    check("async_rst_update", 32'(update), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // Reset in the middle of a count aborts the capture
    repeat (3) @(negedge clk);
    u0 = upd_seen;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    an = 4'hF; seg = 7'h7F;
    hold(10);
    check("rst_abort_no_update", 32'(upd_seen - u0), 32'd0);

    // Scan 9,0,7,blank on digits 0..3
    for (int rep = 0; rep < 2; rep++) begin
      u0 = upd_seen;
      drive(4'b0001, 7'h6F); hold(19);
      drive(4'b0010, 7'h3F); hold(19);
      drive(4'b0100, 7'h07); hold(19);
      drive(4'b1000, 7'h00); hold(19);
      check("scan_update_count", 32'(upd_seen - u0), 32'd4);
    end
    check("scan_digits", 32'(digits), 32'hF709);
    check("scan_valid", 32'(valid), 32'hF);

    // Glitch inside the stable window restarts the count
    u0 = upd_seen;
    drive(4'b0001, 7'h6D); hold(1);
    drive(4'b0001, 7'h7F); hold(10);
    check("glitch_update_count", 32'(upd_seen - u0), 32'd1);
    check("glitch_digit", 32'(digits[3:0]), 32'd8);
    u0 = upd_seen;
    drive(4'b0011, 7'h06); hold(10);
    check("multihot_no_update", 32'(upd_seen - u0), 32'd0);

    // Illegal pattern then a legal 5 on digit 2
    drive(4'b0100, 7'h36); hold(8);
    check("illegal_err", 32'(err), 32'b0100);
    check("illegal_keeps_digit", 32'(digits[11:8]), 32'd7);
    check("illegal_valid", 32'(valid[2]), 32'd1);
    drive(4'b0100, 7'h6D); hold(8);
    check("legal_clears_err", 32'(err[2]), 32'd0);
    check("legal_digit", 32'(digits[11:8]), 32'd5);

    // Timeout: held digit stays valid, released digit expires 64 edges after last refresh
    drive(4'b0010, 7'h06); hold(200);
    check("hold_keeps_valid", 32'(valid[1]), 32'd1);
    drive(4'b0000, 7'h06);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (valid[1] === 1'b0) begin lat = k; break; end
    end
    // last refresh is at edge 1, so the drop lands at edge 1 + 64
    check("timeout_edge", 32'(lat), 32'd65);
    check("timeout_keeps_digit", 32'(digits[7:4]), 32'd1);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      kind = $urandom_range(0, 99);
      ra = 4'(1 << $urandom_range(0, 3));
      if (kind < 70) begin
        hl = $urandom_range(0, 10);
        rs = (hl == 10) ? 7'h00 : SEG_TAB[hl];
      end else if (kind < 85) begin
        rs = 7'($urandom);
      end else begin
        rs = SEG_TAB[$urandom_range(0, 9)];
        ra = 4'($urandom);
      end
      hl = (kind % 10 == 0) ? $urandom_range(60, 90) : $urandom_range(1, 8);
      $display("[TB] txn %0d an_hi=%b seg_hi=%h hold=%0d", t, ra, rs, hl);
      drive(ra, rs);
      hold(hl - 1);
    end
    hold(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
